// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read controller.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StIssue,
    StWaitRise,
    StWaitFall,
    StNext,
    StCsHold,
    StDone
  } state_t;

  typedef enum logic [1:0] {
    PhCmd,
    PhAddr,
    PhDummy,
    PhData
  } phase_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] FILL_BYTE    = 8'h00;

endpackage

// File: rtl/spi_byte_seq.sv
// Launch-and-complete handshake for one byte on the SPI byte engine:
// strobe eng_write once the engine is idle, then wait for its busy pulse to end.
module spi_byte_seq
  import spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_go,
  input  logic [7:0] tx_byte,
  input  logic       eng_busy,
  output logic       byte_done,
  output logic       eng_write,
  output logic [7:0] eng_tx_data
);

  state_t     state_q, state_d;
  logic       busy_q;
  logic [7:0] tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      busy_q  <= eng_busy;
      if (state_q == StIdle && byte_go) begin
        tx_q <= tx_byte;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (byte_go) state_d = StIssue;
      // An engine still busy from elsewhere holds us here without strobing.
      StIssue:    if (!eng_busy) state_d = StWaitRise;
      StWaitRise: if (eng_busy) state_d = StWaitFall;
      StWaitFall: if (busy_q && !eng_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    eng_write   = (state_q == StIssue) && !eng_busy;
    byte_done   = (state_q == StWaitFall) && busy_q && !eng_busy;
    eng_tx_data = tx_q;
  end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// SPI flash READ sequencer: cs_n, opcode, address MSB first, then len data bytes.
// Define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B) with one dummy byte.
module spi_flash_rd_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned LEN_W       = 8,
  parameter logic [7:0]  CMD_READ    = OP_READ,
  parameter int unsigned CS_HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              ctrl_busy,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              done,
  output logic              flash_cs_n,
  output logic [7:0]        eng_tx_data,
  output logic              eng_write,
  input  logic              eng_busy,
  input  logic [7:0]        eng_rx_data
);

  localparam int unsigned CntW      = LEN_W + 1;
  localparam int unsigned AddrBytes = ADDR_W / 8;
  localparam int unsigned HoldW     = (CS_HOLD_CYC > 1) ? $clog2(CS_HOLD_CYC + 1) : 1;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] Opcode      = OP_FAST_READ;
  localparam phase_t     PhAfterAddr = PhDummy;
`else
  localparam logic [7:0] Opcode      = CMD_READ;
  localparam phase_t     PhAfterAddr = PhData;
`endif

  state_t            state_q, state_d;
  phase_t            phase_q;
  logic [CntW-1:0]   cnt_q, cnt_inc, len_tot;
  logic [ADDR_W-1:0] addr_sh_q;
  logic [LEN_W-1:0]  len_q;
  logic [HoldW-1:0]  hold_q;
  logic [7:0]        rd_data_q, tx_byte;
  logic              rd_valid_q, byte_go, byte_done, last_byte, hold_last;

  // len == 0 encodes a full 2^LEN_W transfer; the extra counter bit keeps it from wrapping.
  assign len_tot   = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
  assign cnt_inc   = cnt_q + CntW'(1);
  assign last_byte = (phase_q == PhData) && (cnt_inc == len_tot);
  assign hold_last = (hold_q == HoldW'(CS_HOLD_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCsSetup;
      StCsSetup: state_d = StIssue;
      StIssue:   if (byte_done) state_d = StNext;
      StNext:    state_d = last_byte ? StCsHold : StIssue;
      StCsHold:  if (hold_last) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_busy  = 1'b1;
    flash_cs_n = 1'b0;
    done       = 1'b0;
    byte_go    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ctrl_busy  = 1'b0;
        flash_cs_n = 1'b1;
      end
      StIssue: byte_go = 1'b1;
      StDone: begin
        ctrl_busy  = 1'b0;
        flash_cs_n = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (phase_q)
      PhCmd:   tx_byte = Opcode;
      PhAddr:  tx_byte = addr_sh_q[ADDR_W-1 -: 8];
      default: tx_byte = FILL_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PhCmd;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_sh_q <= addr;
            len_q     <= len;
            phase_q   <= PhCmd;
            cnt_q     <= '0;
            hold_q    <= '0;
          end
        end
        StNext: begin
          unique case (phase_q)
            PhCmd: begin
              phase_q <= PhAddr;
              cnt_q   <= '0;
            end
            PhAddr: begin
              if (cnt_q == CntW'(AddrBytes - 1)) begin
                phase_q <= PhAfterAddr;
                cnt_q   <= '0;
              end else begin
                cnt_q     <= cnt_inc;
                addr_sh_q <= addr_sh_q << 8;
              end
            end
            PhDummy: begin
              phase_q <= PhData;
              cnt_q   <= '0;
            end
            PhData: begin
              rd_data_q  <= eng_rx_data;
              rd_valid_q <= 1'b1;
              cnt_q      <= cnt_inc;
            end
            default: ;
          endcase
        end
        StCsHold: hold_q <= hold_q + HoldW'(1);
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  spi_byte_seq u_byte_seq (
    .clk         (clk),
    .rst         (rst),
    .byte_go     (byte_go),
    .tx_byte     (tx_byte),
    .eng_busy    (eng_busy),
    .byte_done   (byte_done),
    .eng_write   (eng_write),
    .eng_tx_data (eng_tx_data)
  );

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: behavioural byte engine + flash, MOSI/read-data scoreboards.
`timescale 1ns/1ps
module tb_spi_flash_rd_ctrl;

  localparam int CS_HOLD_CYC = 2;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
  localparam int         HDR    = 5;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
  localparam int         HDR    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        ctrl_busy, rd_valid, done, flash_cs_n, eng_write, eng_busy;
  logic [7:0]  rd_data, eng_tx_data, eng_rx_data;
  logic        mdl_busy, ext_busy;

  assign eng_busy = mdl_busy | ext_busy;

  spi_flash_rd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr        (addr),
    .len         (len),
    .ctrl_busy   (ctrl_busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .done        (done),
    .flash_cs_n  (flash_cs_n),
    .eng_tx_data (eng_tx_data),
    .eng_write   (eng_write),
    .eng_busy    (eng_busy),
    .eng_rx_data (eng_rx_data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_err = 0;
  logic [7:0] exp_tx[$], exp_rd[$], fixed_rx[$];
  int         cyc = 0, rv_cnt = 0, done_cnt = 0, cs_rise = 0;
  int         last_rv_cyc = 0, done_cyc = 0, xfer_idx = 0;
  logic       cs_prev = 1'b1, wr_prev = 1'b0, cs_before_done = 1'b1;
  logic [7:0] mdl_rx, mdl_exp;
  int         mdl_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Byte engine + flash: checks MOSI against the queue, returns a byte per transfer.
  initial begin
    mdl_busy    = 1'b0;
    eng_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (flash_cs_n) xfer_idx = 0;
      if (eng_write && !rst) begin
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_err++;
          $display("FAIL tx_extra: got write of %02h, expected no write", eng_tx_data);
        end else begin
          mdl_exp = exp_tx.pop_front();
          if (eng_tx_data !== mdl_exp) begin
            n_err++;
            $display("FAIL mosi_byte%0d: got %02h, expected %02h", xfer_idx, eng_tx_data, mdl_exp);
          end
        end
        if (xfer_idx >= HDR) begin
          mdl_rx = (fixed_rx.size() != 0) ? fixed_rx.pop_front() : 8'($urandom);
          exp_rd.push_back(mdl_rx);
        end else begin
          mdl_rx = 8'($urandom);
        end
        xfer_idx++;
        mdl_lat = 1 + int'($urandom_range(0, 2));
        @(posedge clk);
        #1 mdl_busy = 1'b1;
        repeat (mdl_lat) @(posedge clk);
        #1;
        eng_rx_data = mdl_rx;
        mdl_busy    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rd_valid) begin
        rv_cnt++;
        last_rv_cyc = cyc;
        chk("rd_done_excl", done, 0);
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_err++;
          $display("FAIL rd_extra: got rd_valid with %02h, expected none", rd_data);
        end else begin
          mdl_exp = exp_rd.pop_front();
          if (rd_data !== mdl_exp) begin
            n_err++;
            $display("FAIL rd_data: got %02h, expected %02h", rd_data, mdl_exp);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc       = cyc;
        cs_before_done = cs_prev;
      end
      if (flash_cs_n && !cs_prev) cs_rise++;
      if (eng_write) chk("single_strobe", wr_prev, 0);
    end
    cs_prev = flash_cs_n;
    wr_prev = eng_write;
  end

  task automatic prep(input logic [23:0] a, input int n, input bit clear);
    if (clear) begin
      exp_tx.delete();
      exp_rd.delete();
      fixed_rx.delete();
    end
    exp_tx.push_back(EXP_OP);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
`ifdef SPI_FLASH_FAST_READ_EN
    exp_tx.push_back(8'h00);
`endif
    for (int i = 0; i < n; i++) exp_tx.push_back(8'h00);
  endtask

  task automatic clr_cnt();
    rv_cnt   = 0;
    done_cnt = 0;
    cs_rise  = 0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, (c < 20000), 1);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [7:0]  l;
    bit          fixed;
    int          n_exp;
  } vec_t;

  vec_t vecs[5];

  task automatic run_txn(input vec_t v);
    prep(v.a, v.n_exp, 1'b1);
    if (v.fixed) begin
      fixed_rx.push_back(8'hA5);
      fixed_rx.push_back(8'h5A);
      fixed_rx.push_back(8'hC3);
    end
    clr_cnt();
    start = 1'b1;
    addr  = v.a;
    len   = v.l;
    @(negedge clk);
    start = 1'b0;
    addr  = 24'($urandom);
    len   = 8'($urandom);
    chk("busy_after_start", ctrl_busy, 1);
    chk("cs_low_after_start", flash_cs_n, 0);
    wait_done("txn_done_seen");
    chk("cs_high_at_done", flash_cs_n, 1);
    chk("busy_low_at_done", ctrl_busy, 0);
    repeat (2) @(negedge clk);
    chk("cs_hold_gap", done_cyc - last_rv_cyc, CS_HOLD_CYC);
    chk("cs_low_before_done", cs_before_done, 0);
    chk("rd_count", rv_cnt, v.n_exp);
    chk("done_count", done_cnt, 1);
    chk("cs_windows", cs_rise, 1);
    chk("mosi_all_sent", exp_tx.size(), 0);
    chk("rd_all_seen", exp_rd.size(), 0);
  endtask

  initial begin
    int w, c;
    rst      = 1'b1;
    start    = 1'b0;
    addr     = '0;
    len      = '0;
    ext_busy = 1'b0;

    vecs[0] = '{a: 24'h012345, l: 8'd3, fixed: 1'b1, n_exp: 3};
    vecs[1] = '{a: 24'h000010, l: 8'd1, fixed: 1'b0, n_exp: 1};
    vecs[2] = '{a: 24'hABCDEF, l: 8'd5, fixed: 1'b0, n_exp: 5};
    vecs[3] = '{a: 24'hFFFFFF, l: 8'd2, fixed: 1'b0, n_exp: 2};
    vecs[4] = '{a: 24'h800001, l: 8'd0, fixed: 1'b0, n_exp: 256};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", flash_cs_n, 1);
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_write", eng_write, 0);
    chk("rst_eng_tx_data", eng_tx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // A second start pulse mid-transfer must be ignored.
    prep(24'h112233, 2, 1'b1);
    clr_cnt();
    start = 1'b1;
    addr  = 24'h112233;
    len   = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    addr  = 24'h445566;
    len   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_done_seen");
    repeat (30) @(negedge clk);
    chk("ignore_done_count", done_cnt, 1);
    chk("ignore_rd_count", rv_cnt, 2);
    chk("ignore_cs_windows", cs_rise, 1);
    chk("ignore_mosi_all_sent", exp_tx.size(), 0);

    // start held through DONE: exactly one more transaction, accepted the cycle after done.
    prep(24'h00A0B0, 1, 1'b1);
    prep(24'h00A0B0, 1, 1'b0);
    clr_cnt();
    start = 1'b1;
    addr  = 24'h00A0B0;
    len   = 8'd1;
    wait_done("held_first_done");
    chk("held_busy_at_done", ctrl_busy, 0);
    @(negedge clk);
    chk("held_busy_idle_cycle", ctrl_busy, 0);
    chk("held_cs_idle_cycle", flash_cs_n, 1);
    @(negedge clk);
    chk("held_second_accept", ctrl_busy, 1);
    start = 1'b0;
    wait_done("held_second_done");
    repeat (30) @(negedge clk);
    chk("held_done_count", done_cnt, 2);
    chk("held_rd_count", rv_cnt, 2);
    chk("held_cs_windows", cs_rise, 2);
    chk("held_mosi_all_sent", exp_tx.size(), 0);

    // Reset during the second address byte.
    prep(24'h334455, 4, 1'b1);
    clr_cnt();
    start = 1'b1;
    addr  = 24'h334455;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    c = 0;
    while (w < 3 && c < 200) begin
      @(negedge clk);
      c++;
      if (eng_write) w++;
    end
    chk("rst_mid_reached", w, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs_n", flash_cs_n, 1);
    chk("rst_mid_busy", ctrl_busy, 0);
    chk("rst_mid_eng_write", eng_write, 0);
    chk("rst_mid_rd_valid", rd_valid, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_rd", rv_cnt, 0);
    chk("rst_mid_no_done", done_cnt, 0);
    exp_tx.delete();
    exp_rd.delete();
    run_txn(vecs[0]);

    // Engine still busy when the first byte is ready: no strobe until it drops.
    prep(24'h0F0E0D, 1, 1'b1);
    clr_cnt();
    ext_busy = 1'b1;
    start    = 1'b1;
    addr     = 24'h0F0E0D;
    len      = 8'd1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    repeat (6) begin
      @(negedge clk);
      if (eng_write) w++;
    end
    chk("busy_hold_no_write", w, 0);
    @(posedge clk);
    #1 ext_busy = 1'b0;
    @(negedge clk);
    c = 0;
    while (!eng_write && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("busy_release_strobe", eng_write, 1);
    chk("busy_release_byte", eng_tx_data, EXP_OP);
    @(negedge clk);
    chk("busy_release_single", eng_write, 0);
    wait_done("busy_done_seen");
    repeat (2) @(negedge clk);
    chk("busy_rd_count", rv_cnt, 1);
    chk("busy_done_count", done_cnt, 1);
    chk("busy_mosi_all_sent", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
